// File: rtl/ats21_cmd_scheduler.sv
// rtl/ats21_cmd_scheduler.sv - two-client command scheduler for the ATS21 timer core
module ats21_cmd_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STAT_WAIT     = 2,
    parameter int READY_TIMEOUT = 15
) (
    input  logic        clk_1x,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [31:0] a_inst,
    output logic        a_ready,
    output logic        a_rsp_valid,
    output logic        a_rsp_ack,
    input  logic        b_valid,
    input  logic [31:0] b_inst,
    output logic        b_ready,
    output logic        b_rsp_valid,
    output logic        b_rsp_ack,
    output logic        dev_req,
    input  logic        dev_ready,
    output logic [15:0] dev_ctrlA,
    output logic [15:0] dev_ctrlB,
    input  logic [1:0]  dev_stat,
    output logic        busy
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    PTR_ONE   = (AW+1)'(1);
    localparam logic [7:0]     TMO_LAST  = 8'(READY_TIMEOUT - 1);
    localparam logic [2:0]     EXEC_LAST = 3'(STAT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RDY,
        S_LO,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Per-client FIFOs: extra pointer bit distinguishes full from empty
    logic [31:0] fa_mem [FIFO_DEPTH];
    logic [31:0] fb_mem [FIFO_DEPTH];
    logic [AW:0] fa_wr, fa_rd, fb_wr, fb_rd;
    logic        fa_empty, fa_full, fb_empty, fb_full;
    logic        push_a, push_b, pick_a, pick_b, rr_toggle;
    logic [31:0] ha, hb;

    // Issued pair and transaction bookkeeping
    logic [31:0] lane_a, lane_b;
    logic [1:0]  lane_used;
    logic [1:0]  stat_q;
    logic        rr_ptr;                 // 0 = client A has priority on conflict
    logic [7:0]  tmo_cnt;
    logic [2:0]  exec_cnt;
    logic        timeout, exec_last, conflict;

    assign fa_empty = (fa_wr == fa_rd);
    assign fb_empty = (fb_wr == fb_rd);
    assign fa_full  = (fa_wr[AW] != fa_rd[AW]) && (fa_wr[AW-1:0] == fa_rd[AW-1:0]);
    assign fb_full  = (fb_wr[AW] != fb_rd[AW]) && (fb_wr[AW-1:0] == fb_rd[AW-1:0]);
    assign a_ready  = !fa_full;
    assign b_ready  = !fb_full;
    assign push_a   = a_valid && !fa_full;
    assign push_b   = b_valid && !fb_full;
    assign ha       = fa_mem[fa_rd[AW-1:0]];
    assign hb       = fb_mem[fb_rd[AW-1:0]];

    // Opcode-class conflict check on the top byte of each head
    function automatic logic is_conflict(input logic [7:0] x, input logic [7:0] y);
        logic x_clk, y_clk, x_alm, y_alm;
        x_clk = (x[7:5] == 3'b001) || (x[7:5] == 3'b010);
        y_clk = (y[7:5] == 3'b001) || (y[7:5] == 3'b010);
        x_alm = (x[7:5] >= 3'b101);
        y_alm = (y[7:5] >= 3'b101);
        is_conflict = (x_clk && y_clk && (x[4:1] == y[4:1]))
                   || (x_alm && y_alm && (x[4:0] == y[4:0]))
                   || ((x[7:5] == 3'b011) && (y[7:5] == 3'b011));
    endfunction

    assign conflict  = is_conflict(ha[31:24], hb[31:24]);
    assign timeout   = (state_q == S_WAIT_RDY) && !dev_ready && (tmo_cnt == TMO_LAST);
    assign exec_last = (state_q == S_EXEC) && (exec_cnt == EXEC_LAST);
    assign busy      = (state_q != S_IDLE);

    // FIFO pointers; a pop and a push on the same edge both take effect
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            fa_wr <= '0;
            fa_rd <= '0;
            fb_wr <= '0;
            fb_rd <= '0;
        end else begin
            if (push_a) fa_wr <= fa_wr + PTR_ONE;
            if (pick_a) fa_rd <= fa_rd + PTR_ONE;
            if (push_b) fb_wr <= fb_wr + PTR_ONE;
            if (pick_b) fb_rd <= fb_rd + PTR_ONE;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them
    always_ff @(posedge clk_1x) begin
        if (push_a) fa_mem[fa_wr[AW-1:0]] <= a_inst;
        if (push_b) fb_mem[fb_wr[AW-1:0]] <= b_inst;
    end

    // Choose which heads to issue while idle
    always_comb begin
        pick_a    = 1'b0;
        pick_b    = 1'b0;
        rr_toggle = 1'b0;
        if (state_q == S_IDLE) begin
            if (!fa_empty && !fb_empty) begin
                if (!conflict) begin
                    pick_a = 1'b1;
                    pick_b = 1'b1;
                end else begin
                    rr_toggle = 1'b1;
                    pick_a    = !rr_ptr;
                    pick_b    = rr_ptr;
                end
            end else if (!fa_empty) begin
                pick_a = 1'b1;
            end else if (!fb_empty) begin
                pick_b = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and device/client outputs
    always_comb begin
        state_d     = state_q;
        dev_req     = 1'b0;
        dev_ctrlA   = 16'h0;
        dev_ctrlB   = 16'h0;
        a_rsp_valid = 1'b0;
        a_rsp_ack   = 1'b0;
        b_rsp_valid = 1'b0;
        b_rsp_ack   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_a || pick_b) state_d = S_REQ;
            end
            S_REQ: begin
                dev_req = 1'b1;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                dev_ctrlA = lane_a[31:16];
                dev_ctrlB = lane_b[31:16];
                if (dev_ready)    state_d = S_LO;
                else if (timeout) state_d = S_RESP;
            end
            S_LO: begin
                dev_ctrlA = lane_a[15:0];
                dev_ctrlB = lane_b[15:0];
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (exec_last) state_d = S_RESP;
            end
            S_RESP: begin
                a_rsp_valid = lane_used[0];
                a_rsp_ack   = lane_used[0] && stat_q[0];
                b_rsp_valid = lane_used[1];
                b_rsp_ack   = lane_used[1] && stat_q[1];
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the issued pair, advance round-robin, run phase counters, capture status
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            lane_a    <= '0;
            lane_b    <= '0;
            lane_used <= '0;
            stat_q    <= '0;
            rr_ptr    <= 1'b0;
            tmo_cnt   <= '0;
            exec_cnt  <= '0;
        end else begin
            if (pick_a || pick_b) begin
                lane_a    <= pick_a ? ha : 32'h0;
                lane_b    <= pick_b ? hb : 32'h0;
                lane_used <= {pick_b, pick_a};
                stat_q    <= 2'b00;
            end
            if (rr_toggle) rr_ptr <= !rr_ptr;
            if (state_q == S_REQ)           tmo_cnt <= '0;
            else if (state_q == S_WAIT_RDY) tmo_cnt <= tmo_cnt + 8'd1;
            if (state_q == S_LO)            exec_cnt <= '0;
            else if (state_q == S_EXEC)     exec_cnt <= exec_cnt + 3'd1;
            if (timeout)                    stat_q <= 2'b00;
            else if (exec_last)             stat_q <= dev_stat;
        end
    end

endmodule

// File: tb/tb_ats21_cmd_scheduler.sv
// tb/tb_ats21_cmd_scheduler.sv - self-checking bench for ats21_cmd_scheduler
module tb_ats21_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int SW    = 2;
    localparam int TMO   = 15;

    logic        clk_1x, reset;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_inst, b_inst;
    logic        a_rsp_valid, a_rsp_ack, b_rsp_valid, b_rsp_ack;
    logic        dev_req, dev_ready, busy;
    logic [15:0] dev_ctrlA, dev_ctrlB;
    logic [1:0]  dev_stat;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    int       rdy_mode = 1;      // 0 tied low, 1 tied high, 2 random
    logic [1:0] stat_fix = 2'b01;
    bit       stat_rand = 0;

    ats21_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .STAT_WAIT(SW), .READY_TIMEOUT(TMO)) dut (
        .clk_1x(clk_1x), .reset(reset),
        .a_valid(a_valid), .a_inst(a_inst), .a_ready(a_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack),
        .b_valid(b_valid), .b_inst(b_inst), .b_ready(b_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack),
        .dev_req(dev_req), .dev_ready(dev_ready),
        .dev_ctrlA(dev_ctrlA), .dev_ctrlB(dev_ctrlB),
        .dev_stat(dev_stat), .busy(busy)
    );

    initial begin
        clk_1x = 0;
        forever #5 clk_1x = ~clk_1x;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Device side: ready and status change just after each edge
    initial begin
        dev_ready = 0;
        dev_stat  = 0;
        forever begin
            @(posedge clk_1x);
            #1;
            case (rdy_mode)
                0:       dev_ready = 0;
                1:       dev_ready = 1;
                default: dev_ready = ($urandom_range(0, 3) == 0);
            endcase
            dev_stat = stat_rand ? 2'($urandom_range(0, 3)) : stat_fix;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] qa[$], qb[$];
    bit          m_busy = 0, m_rr = 0, ua = 0, ub = 0, pa, pb;
    logic [31:0] la = 0, lb = 0;
    logic [1:0]  mstat = 0;
    int          age = 0, lo_age = -1, resp_age = -1;

    function automatic int op_class(input logic [2:0] op);
        case (op)
            3'b001, 3'b010:         return 1;
            3'b101, 3'b110, 3'b111: return 2;
            3'b011:                 return 3;
            default:                return 0;
        endcase
    endfunction

    function automatic bit clash(input logic [31:0] x, input logic [31:0] y);
        int cx, cy;
        cx = op_class(x[31:29]);
        cy = op_class(y[31:29]);
        if (cx == 0 || cx != cy) return 0;
        if (cx == 3) return 1;
        if (cx == 1) return x[28:25] == y[28:25];
        return x[28:24] == y[28:24];
    endfunction

    // Advance the model by one clock using the inputs present during the cycle
    always @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            m_busy = 0; m_rr = 0; ua = 0; ub = 0;
        end else begin
            pa = a_valid && (qa.size() < DEPTH);
            pb = b_valid && (qb.size() < DEPTH);
            if (!m_busy) begin
                if (qa.size() > 0 || qb.size() > 0) begin
                    ua = 0; ub = 0;
                    if (qa.size() > 0 && qb.size() > 0) begin
                        if (!clash(qa[0], qb[0])) begin
                            ua = 1; ub = 1;
                        end else begin
                            if (m_rr == 0) ua = 1; else ub = 1;
                            m_rr = !m_rr;
                        end
                    end else if (qa.size() > 0) ua = 1;
                    else ub = 1;
                    la = ua ? qa.pop_front() : 32'h0;
                    lb = ub ? qb.pop_front() : 32'h0;
                    m_busy = 1; age = 0; lo_age = -1; resp_age = -1; mstat = 0;
                end
            end else if (age == resp_age) begin
                m_busy = 0;
            end else begin
                if (age >= 1 && lo_age < 0 && resp_age < 0) begin
                    if (dev_ready) begin
                        lo_age   = age + 1;
                        resp_age = age + 2 + SW;
                    end else if (age == TMO) begin
                        resp_age = age + 1;
                    end
                end else if (lo_age >= 0 && age == resp_age - 1) begin
                    mstat = dev_stat;
                end
                age++;
            end
            if (pa) qa.push_back(a_inst);
            if (pb) qb.push_back(b_inst);
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk_1x) begin
        if (chk_en) begin
            bit hi, lo, rsp;
            hi  = m_busy && age >= 1 && lo_age < 0 && resp_age < 0;
            lo  = m_busy && lo_age >= 0 && age == lo_age;
            rsp = m_busy && age == resp_age;
            chk("a_ready", a_ready, qa.size() < DEPTH);
            chk("b_ready", b_ready, qb.size() < DEPTH);
            chk("busy", busy, m_busy);
            chk("dev_req", dev_req, m_busy && age == 0);
            chk("dev_ctrlA", dev_ctrlA, hi ? la[31:16] : lo ? la[15:0] : 16'h0);
            chk("dev_ctrlB", dev_ctrlB, hi ? lb[31:16] : lo ? lb[15:0] : 16'h0);
            chk("a_rsp_valid", a_rsp_valid, rsp && ua);
            chk("a_rsp_ack", a_rsp_ack, rsp && ua && mstat[0]);
            chk("b_rsp_valid", b_rsp_valid, rsp && ub);
            chk("b_rsp_ack", b_rsp_ack, rsp && ub && mstat[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input bit da, input logic [31:0] ia, input bit db, input logic [31:0] ib);
        a_valid = da; a_inst = ia; b_valid = db; b_inst = ib;
        @(posedge clk_1x);
        #1;
        a_valid = 0; b_valid = 0;
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_1x);
            done = !m_busy && qa.size() == 0 && qb.size() == 0;
        end
        chk(name, done, 1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [2:0] op;
        logic [4:0] f;
        op = 3'($urandom_range(0, 7));
        f  = 5'($urandom_range(0, 3));
        return {op, f, 24'($urandom)};
    endfunction

    // ---------------- directed and random sequences ----------------
    initial begin
        int n, nreq, a_c, b_c, last_req, nrsp, cyc;
        bit seen, prev_req, av, bv, aa, ba;
        logic [15:0] hia1, hib1, hia2, hib2;

        reset = 1; a_valid = 0; b_valid = 0; a_inst = 0; b_inst = 0;
        repeat (3) @(negedge clk_1x);
        chk_en = 1;
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", dev_req, 0);
        #2 reset = 0;
        @(posedge clk_1x); #1;

        // 1: single A instruction, beats and latency
        rdy_mode = 1; stat_fix = 2'b01;
        push(1, 32'h2000_0005, 0, 0);
        seen = 0; n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_1x); n++;
            if (n == 2) chk("t1_req", dev_req, 1);
            if (n == 3) begin chk("t1_hiA", dev_ctrlA, 16'h2000); chk("t1_hiB", dev_ctrlB, 16'h0); end
            if (n == 4) begin chk("t1_loA", dev_ctrlA, 16'h0005); chk("t1_loB", dev_ctrlB, 16'h0); end
            if (a_rsp_valid) begin
                seen = 1;
                chk("t1_ack", a_rsp_ack, 1);
                chk("t1_no_b", b_rsp_valid, 0);
            end
        end
        chk("t1_seen", seen, 1);
        chk("t1_latency", n, 7);
        drain("t1_drain", 30);

        // 2: conflicting clk3 pair issues A then B, NOP on other lane
        push(1, 32'h2600_0000, 1, 32'h2640_0000);
        nreq = 0; a_c = -1; b_c = -1; prev_req = 0; cyc = 0;
        hia1 = 16'hffff; hib1 = 16'hffff; hia2 = 16'hffff; hib2 = 16'hffff;
        for (int i = 0; i < 60 && (a_c < 0 || b_c < 0); i++) begin
            @(negedge clk_1x); cyc++;
            if (prev_req && nreq == 1) begin hia1 = dev_ctrlA; hib1 = dev_ctrlB; end
            if (prev_req && nreq == 2) begin hia2 = dev_ctrlA; hib2 = dev_ctrlB; end
            prev_req = dev_req;
            if (dev_req) nreq++;
            if (a_rsp_valid) a_c = cyc;
            if (b_rsp_valid) b_c = cyc;
        end
        chk("t2_both_seen", (a_c > 0) && (b_c > 0), 1);
        chk("t2_a_first", a_c < b_c, 1);
        chk("t2_reqs", nreq, 2);
        chk("t2_hiA1", hia1, 16'h2600);
        chk("t2_hiB1", hib1, 16'h0000);
        chk("t2_hiA2", hia2, 16'h0000);
        chk("t2_hiB2", hib2, 16'h2640);
        drain("t2_drain", 30);

        // 3 and 6: non-conflicting pairs issue together
        for (int t = 0; t < 2; t++) begin
            stat_fix = (t == 0) ? 2'b11 : 2'b10;
            if (t == 0) push(1, 32'hA500_0000, 1, 32'h2400_0000);
            else        push(1, 32'h2200_0001, 1, 32'h2400_0002);
            seen = 0; nreq = 0; av = 0; bv = 0; aa = 0; ba = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk_1x);
                if (dev_req) nreq++;
                if (a_rsp_valid || b_rsp_valid) begin
                    seen = 1; av = a_rsp_valid; bv = b_rsp_valid; aa = a_rsp_ack; ba = b_rsp_ack;
                end
            end
            chk("pair_seen", seen, 1);
            chk("pair_reqs", nreq, 1);
            chk("pair_a_valid", av, 1);
            chk("pair_b_valid", bv, 1);
            chk("pair_a_ack", aa, (t == 0) ? 1 : 0);
            chk("pair_b_ack", ba, 1);
            drain("pair_drain", 30);
        end

        // 4: device never ready, FIFO fills, every transaction times out
        rdy_mode = 0; stat_fix = 2'b11;
        for (int i = 0; i < 5; i++) push(1, 32'h6000_0000 | i, 0, 0);
        @(negedge clk_1x);
        chk("t4_full", a_ready, 0);
        push(1, 32'h6000_00FF, 0, 0);
        nrsp = 0; last_req = -1; cyc = 0;
        for (int i = 0; i < 200 && nrsp < 5; i++) begin
            @(negedge clk_1x); cyc++;
            if (dev_req) last_req = cyc;
            if (a_rsp_valid) begin
                nrsp++;
                chk("t4_nack", a_rsp_ack, 0);
                if (last_req > 0) chk("t4_timeout_len", cyc - last_req, TMO + 1);
            end
        end
        chk("t4_rsp_count", nrsp, 5);
        rdy_mode = 1;
        drain("t4_drain", 60);

        // 5: reset during the low beat drops in-flight and queued work
        stat_fix = 2'b01;
        push(1, 32'h2000_0007, 0, 0);
        push(0, 0, 1, 32'h2400_0009);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_1x);
            seen = (dev_ctrlA == 16'h0007);
        end
        chk("t5_lo_seen", seen, 1);
        #2 reset = 1;
        #1;
        chk("t5_req", dev_req, 0);
        chk("t5_ctrlA", dev_ctrlA, 0);
        chk("t5_busy", busy, 0);
        chk("t5_a_ready", a_ready, 1);
        chk("t5_rsp", a_rsp_valid | b_rsp_valid, 0);
        repeat (2) @(posedge clk_1x);
        @(negedge clk_1x); #2 reset = 0;
        nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1x);
            if (a_rsp_valid || b_rsp_valid) nrsp++;
        end
        chk("t5_no_rsp", nrsp, 0);
        @(posedge clk_1x); #1;
        push(1, 32'h2000_0003, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_1x);
            if (a_rsp_valid) begin seen = 1; chk("t5_after_ack", a_rsp_ack, 1); end
        end
        chk("t5_after_seen", seen, 1);
        drain("t5_drain", 30);

        // Random traffic against the model
        @(posedge clk_1x); #1;
        rdy_mode = 2; stat_rand = 1;
        for (int i = 0; i < 800; i++) begin
            a_valid = ($urandom_range(0, 1) == 1); a_inst = rand_inst();
            b_valid = ($urandom_range(0, 1) == 1); b_inst = rand_inst();
            @(posedge clk_1x); #1;
        end
        a_valid = 0; b_valid = 0;
        rdy_mode = 1;
        drain("rand_drain", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
